// File: rtl/usr_pkg.sv
// Shared definitions for the universal shift register: mode codes and FSM state encoding.
package usr_pkg;

    // Operation select codes, sampled by the top while idle
    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_SHL  = 3'b001;
    localparam logic [2:0] MODE_SHR  = 3'b010;
    localparam logic [2:0] MODE_LOAD = 3'b011;
    localparam logic [2:0] MODE_ASR  = 3'b100;
    localparam logic [2:0] MODE_ROL  = 3'b101;
    localparam logic [2:0] MODE_ROR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    // Controller states
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

endpackage : usr_pkg

// File: rtl/usr_bit_slice.sv
// One register bit: next-value multiplexer plus async-reset flop.
// Neighbour bits arrive already resolved by the top (serial fill, sign or
// wrap-around at the ends), so every slice is identical.
module usr_bit_slice
    import usr_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sel,
    input  logic       own_bit,
    input  logic       left_bit,   // next more-significant bit (or msb fill)
    input  logic       right_bit,  // next less-significant bit (or lsb fill)
    input  logic       par_bit,
    output logic       q
);

    logic d;

    // Select the next value of this bit
    always_comb begin
        d = own_bit;
        case (sel)
            MODE_SHL,
            MODE_ROL:  d = right_bit;
            MODE_SHR,
            MODE_ASR,
            MODE_ROR:  d = left_bit;
            MODE_LOAD: d = par_bit;
            MODE_CLR:  d = 1'b0;
            default:   d = own_bit;
        endcase
    end

    // Storage flop, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule : usr_bit_slice

// File: rtl/usr_shift_reg_n.sv
// Parametrised universal shift register with a self-timed LSB-first transmit burst.
// Optional rotate modes are enabled by defining USR_ROTATE_EN; without it the
// rotate codes hold the register.
module usr_shift_reg_n
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = 8
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] par_in,
    input  logic             sin_lsb,
    input  logic             sin_msb,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             ser_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("usr_shift_reg_n: WIDTH must be in 2..32");
        end
    endgenerate

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [2:0]       mode_eff;
    logic [2:0]       sel;
    logic             fill_msb;
    logic             fill_lsb;
    logic [WIDTH-1:0] left_nb;
    logic [WIDTH-1:0] right_nb;

    // Map the rotate codes onto hold when the rotate feature is not built
    always_comb begin
`ifdef USR_ROTATE_EN
        mode_eff = mode;
`else
        mode_eff = ((mode == MODE_ROL) || (mode == MODE_ROR)) ? MODE_HOLD : mode;
`endif
    end

    // Next-state, counter and datapath-select decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel     = MODE_HOLD;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sel     = MODE_LOAD;
                    cnt_d   = '0;
                    state_d = ST_BURST;
                end else begin
                    sel = mode_eff;
                end
            end
            ST_BURST: begin
                sel = MODE_SHR;
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // End-of-register fill bits depend on the operation in progress
    always_comb begin
        fill_lsb = sin_lsb;
        fill_msb = sin_msb;
        case (sel)
            MODE_ROL: fill_lsb = q[WIDTH-1];
            MODE_ASR: fill_msb = q[WIDTH-1];
            MODE_ROR: fill_msb = q[0];
            default: begin
                fill_lsb = sin_lsb;
                fill_msb = sin_msb;
            end
        endcase
    end

    // Per-bit datapath: neighbour wiring and one slice per bit
    genvar i;
    generate
        for (i = 0; i < int'(WIDTH); i++) begin : g_bit
            if (i == 0) begin : g_lsb
                assign right_nb[i] = fill_lsb;
            end else begin : g_inner_r
                assign right_nb[i] = q[i-1];
            end

            if (i == int'(WIDTH) - 1) begin : g_msb
                assign left_nb[i] = fill_msb;
            end else begin : g_inner_l
                assign left_nb[i] = q[i+1];
            end

            usr_bit_slice u_slice (
                .clk       (clk),
                .rst       (rst),
                .sel       (sel),
                .own_bit   (q[i]),
                .left_bit  (left_nb[i]),
                .right_bit (right_nb[i]),
                .par_bit   (par_in[i]),
                .q         (q[i])
            );
        end
    endgenerate

    // Controller state, counter and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy    <= (state_d == ST_BURST);
            done    <= (state_d == ST_BURST) && (cnt_d == CNT_LAST);
        end
    end

    // Serial output is the current least-significant bit
    assign ser_out = q[0];

endmodule : usr_shift_reg_n

// File: tb/tb_usr_shift_reg_n.sv
// Self-checking bench for usr_shift_reg_n at WIDTH=8 and WIDTH=2.
// Honours USR_ROTATE_EN for the rotate expectations.
module tb_usr_shift_reg_n;

    logic       clk;
    logic       rst;

    logic [2:0] mode8;
    logic [7:0] par8;
    logic       sinl8, sinm8, start8;
    logic [7:0] q8;
    logic       ser8, busy8, done8;

    logic [2:0] mode2;
    logic [1:0] par2;
    logic       sinl2, sinm2, start2;
    logic [1:0] q2;
    logic       ser2, busy2, done2;

    int n_pass;
    int n_total;

    usr_shift_reg_n #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .mode(mode8), .par_in(par8),
        .sin_lsb(sinl8), .sin_msb(sinm8), .start(start8),
        .q(q8), .ser_out(ser8), .busy(busy8), .done(done8)
    );

    usr_shift_reg_n #(.WIDTH(2)) dut2 (
        .clk(clk), .rst(rst), .mode(mode2), .par_in(par2),
        .sin_lsb(sinl2), .sin_msb(sinm2), .start(start2),
        .q(q2), .ser_out(ser2), .busy(busy2), .done(done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #3;
        n_total++; if (q8 !== 8'h00) $display("FAIL reset_q8 got %h exp 00", q8); else n_pass++;
        n_total++; if ({busy8, done8, ser8} !== 3'b000) $display("FAIL reset_flags8 got %b exp 000", {busy8, done8, ser8}); else n_pass++;
        n_total++; if ({q2, busy2, done2} !== 4'b0000) $display("FAIL reset_w2 got %b exp 0000", {q2, busy2, done2}); else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        tick();
    endtask

    // Load 0x3C, then assert reset between edges and check the effect at once
    task automatic test_reset_mid();
        mode8 = 3'b011; par8 = 8'h3C;
        tick();
        mode8 = 3'b000;
        n_total++; if (q8 !== 8'h3C) $display("FAIL pre_reset_load got %h exp 3c", q8); else n_pass++;
        #2 rst = 1'b1;
        #1;
        n_total++; if ({q8, busy8, done8, ser8} !== 11'h000) $display("FAIL async_reset got q=%h busy=%b done=%b exp q=00 busy=0 done=0", q8, busy8, done8); else n_pass++;
        #1 rst = 1'b0;
        tick();
    endtask

    task automatic test_modes();
        logic [2:0] modes [5];
        logic [7:0] expv  [5];
        modes = '{3'b011, 3'b001, 3'b010, 3'b100, 3'b111};
        expv  = '{8'h96, 8'h2D, 8'h16, 8'h0B, 8'h00};
        par8 = 8'h96; sinl8 = 1'b1; sinm8 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mode8 = modes[i];
            tick();
            n_total++;
            if (q8 !== expv[i]) $display("FAIL mode_%0d got %h exp %h", modes[i], q8, expv[i]); else n_pass++;
        end
        mode8 = 3'b000;
        tick();
        n_total++; if (q8 !== 8'h00) $display("FAIL hold got %h exp 00", q8); else n_pass++;
    endtask

    task automatic test_asr_sign();
        logic [7:0] expv [3];
        expv = '{8'hC0, 8'hE0, 8'hF0};
        mode8 = 3'b011; par8 = 8'h80; sinm8 = 1'b0;
        tick();
        mode8 = 3'b100;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_total++;
            if (q8 !== expv[i]) $display("FAIL asr_%0d got %h exp %h", i, q8, expv[i]); else n_pass++;
        end
        mode8 = 3'b000;
    endtask

    task automatic test_burst();
        logic [7:0] word;
        word = 8'hA5;
        par8 = word; sinm8 = 1'b0; mode8 = 3'b011; start8 = 1'b1;
        tick();
        start8 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            n_total++; if (ser8 !== word[k]) $display("FAIL burst_bit%0d got %b exp %b", k, ser8, word[k]); else n_pass++;
            n_total++; if (busy8 !== 1'b1) $display("FAIL burst_busy%0d got %b exp 1", k, busy8); else n_pass++;
            n_total++; if (done8 !== (k == 7)) $display("FAIL burst_done%0d got %b exp %b", k, done8, (k == 7)); else n_pass++;
            start8 = ~start8;
            mode8  = 3'($urandom_range(0, 7));
            par8   = 8'($urandom);
            tick();
        end
        start8 = 1'b0; mode8 = 3'b000;
        n_total++; if ({busy8, done8} !== 2'b00) $display("FAIL burst_end_flags got %b exp 00", {busy8, done8}); else n_pass++;
        n_total++; if (q8 !== 8'h00) $display("FAIL burst_end_q got %h exp 00", q8); else n_pass++;
    endtask

    task automatic test_rotate();
        logic [7:0] exp_rol;
        logic [7:0] exp_ror;
`ifdef USR_ROTATE_EN
        exp_rol = 8'h03; exp_ror = 8'hC0;
`else
        exp_rol = 8'h81; exp_ror = 8'h81;
`endif
        sinl8 = 1'b0; sinm8 = 1'b0;
        mode8 = 3'b011; par8 = 8'h81; tick();
        mode8 = 3'b101; tick();
        n_total++; if (q8 !== exp_rol) $display("FAIL rol got %h exp %h", q8, exp_rol); else n_pass++;
        mode8 = 3'b011; tick();
        mode8 = 3'b110; tick();
        n_total++; if (q8 !== exp_ror) $display("FAIL ror got %h exp %h", q8, exp_ror); else n_pass++;
        mode8 = 3'b000;
    endtask

    task automatic test_width2();
        par2 = 2'b10; sinm2 = 1'b0; start2 = 1'b1;
        tick();
        start2 = 1'b0;
        n_total++; if ({ser2, busy2, done2} !== 3'b010) $display("FAIL w2_c0 got %b exp 010", {ser2, busy2, done2}); else n_pass++;
        tick();
        n_total++; if ({ser2, busy2, done2} !== 3'b111) $display("FAIL w2_c1 got %b exp 111", {ser2, busy2, done2}); else n_pass++;
        tick();
        n_total++; if ({q2, busy2, done2} !== 4'b0000) $display("FAIL w2_end got %b exp 0000", {q2, busy2, done2}); else n_pass++;
    endtask

    // start held high: not honoured at the done edge, honoured on the next idle cycle;
    // then a reset in the middle of that second burst
    task automatic test_back_to_back();
        par8 = 8'h5A; sinm8 = 1'b1; start8 = 1'b1;
        for (int c = 0; c < 8; c++) tick();
        n_total++; if (done8 !== 1'b1) $display("FAIL b2b_done got %b exp 1", done8); else n_pass++;
        tick();
        n_total++; if ({busy8, q8} !== {1'b0, 8'hFF}) $display("FAIL b2b_idle got busy=%b q=%h exp busy=0 q=ff", busy8, q8); else n_pass++;
        tick();
        n_total++; if ({busy8, q8} !== {1'b1, 8'h5A}) $display("FAIL b2b_restart got busy=%b q=%h exp busy=1 q=5a", busy8, q8); else n_pass++;
        start8 = 1'b0;
        tick(); tick();
        pulse_reset();
        n_total++; if ({q8, busy8, done8} !== 10'h000) $display("FAIL b2b_reset got q=%h busy=%b done=%b exp zeros", q8, busy8, done8); else n_pass++;
        tick();
        n_total++; if (busy8 !== 1'b0) $display("FAIL b2b_reset_stays_idle got %b exp 0", busy8); else n_pass++;
    endtask

    // Random traffic against a word-level model of the register
    task automatic test_random();
        logic [7:0] m_q;
        bit         m_busy;
        int         m_k;
        logic       exp_done;
        pulse_reset();
        m_q = 8'h00; m_busy = 0; m_k = 0;
        for (int n = 0; n < 400; n++) begin
            mode8  = 3'($urandom_range(0, 7));
            par8   = 8'($urandom);
            sinl8  = 1'($urandom);
            sinm8  = 1'($urandom);
            start8 = ($urandom_range(0, 7) == 0);
            if (m_busy) begin
                m_q = 8'((m_q >> 1) | (8'(sinm8) << 7));
                if (m_k == 7) begin m_busy = 0; m_k = 0; end
                else m_k++;
            end else if (start8) begin
                m_q = par8; m_busy = 1; m_k = 0;
            end else begin
                case (mode8)
                    3'd1: m_q = 8'((m_q << 1) | 8'(sinl8));
                    3'd2: m_q = 8'((m_q >> 1) | (8'(sinm8) << 7));
                    3'd3: m_q = par8;
                    3'd4: m_q = 8'((m_q >> 1) | (m_q & 8'h80));
`ifdef USR_ROTATE_EN
                    3'd5: m_q = 8'((m_q << 1) | (m_q >> 7));
                    3'd6: m_q = 8'((m_q >> 1) | (m_q << 7));
`endif
                    3'd7: m_q = 8'h00;
                    default: m_q = m_q;
                endcase
            end
            exp_done = m_busy && (m_k == 7);
            tick();
            n_total++; if (q8 !== m_q) $display("FAIL rand_q[%0d] got %h exp %h", n, q8, m_q); else n_pass++;
            n_total++; if (ser8 !== m_q[0]) $display("FAIL rand_ser[%0d] got %b exp %b", n, ser8, m_q[0]); else n_pass++;
            n_total++; if (busy8 !== m_busy) $display("FAIL rand_busy[%0d] got %b exp %b", n, busy8, m_busy); else n_pass++;
            n_total++; if (done8 !== exp_done) $display("FAIL rand_done[%0d] got %b exp %b", n, done8, exp_done); else n_pass++;
        end
        start8 = 1'b0; mode8 = 3'b000;
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        rst = 1'b0;
        mode8 = 3'b000; par8 = 8'h00; sinl8 = 1'b0; sinm8 = 1'b0; start8 = 1'b0;
        mode2 = 3'b000; par2 = 2'b00; sinl2 = 1'b0; sinm2 = 1'b0; start2 = 1'b0;
        test_reset();
        test_reset_mid();
        test_modes();
        test_asr_sign();
        test_burst();
        test_rotate();
        test_width2();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_usr_shift_reg_n
